regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback arbiter:
// data/address widths, requester indices and the round-robin pointer encoding.
package regfile_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 2;

  // Bit positions of each requester in request/grant vectors
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  // Which requester wins when both ask in the same cycle
  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_MEM = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with one-hot grants.
// A lone request always wins. When both requests are present, the pointer
// chooses the winner, and the pointer then moves to the other requester.
// Nothing is granted while hold is high or while reset is asserted.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  rr_ptr_e ptr_reg;

  // Combinational grant from requests, hold, reset and the pointer
  always_comb begin
    grant = 2'b00;
    if (rst && !hold) begin
      if (req[REQ_ALU] && req[REQ_MEM]) begin
        if (ptr_reg == PTR_MEM) begin
          grant[REQ_MEM] = 1'b1;
        end else begin
          grant[REQ_ALU] = 1'b1;
        end
      end else begin
        grant = req;
      end
    end
  end

  // Point to the requester that did not win; keep the pointer when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= PTR_ALU;
    end else if (grant[REQ_ALU]) begin
      ptr_reg <= PTR_MEM;
    end else if (grant[REQ_MEM]) begin
      ptr_reg <= PTR_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file write port.
// Arbitrates the ALU and load-unit writeback channels, registers the winner
// into a one-cycle output stage, flags read-after-write hazards for decode,
// and counts committed writes.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [W-1:0]          alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [W-1:0]          mem_data,
  output logic                  mem_ready,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_destination,
  output logic [W-1:0]          write_data,
  input  logic [REG_ADDR_W-1:0] read_sources_1,
  input  logic [REG_ADDR_W-1:0] read_sources_2,
  output logic                  stall,
  output logic [15:0]           wr_count
);

  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  we_reg;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic [W-1:0]          data_reg;
  logic [15:0]           count_reg;
  logic                  alu_pending;
  logic                  mem_pending;

  assign req[REQ_ALU] = alu_valid;
  assign req[REQ_MEM] = mem_valid;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .req  (req),
    .grant(grant)
  );

  // A grant is only ever issued to a valid channel, so ready == transfer
  assign alu_ready = grant[REQ_ALU];
  assign mem_ready = grant[REQ_MEM];

  // Output stage: capture the granted write; dest/data hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_reg   <= 1'b0;
      dest_reg <= '0;
      data_reg <= '0;
    end else begin
      we_reg <= |grant;
      if (grant[REQ_ALU]) begin
        dest_reg <= alu_dest;
        data_reg <= alu_data;
      end else if (grant[REQ_MEM]) begin
        dest_reg <= mem_dest;
        data_reg <= mem_data;
      end
    end
  end

  // Count every write presented to the register file, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (we_reg) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // A channel still waiting to write will change its dest register later
  assign alu_pending = alu_valid && !grant[REQ_ALU];
  assign mem_pending = mem_valid && !grant[REQ_MEM];

  // Hazard when a decode source matches the staged write or a pending request
  always_comb begin
    stall = 1'b0;
    if (we_reg && (read_sources_1 == dest_reg || read_sources_2 == dest_reg)) begin
      stall = 1'b1;
    end
    if (alu_pending && (read_sources_1 == alu_dest || read_sources_2 == alu_dest)) begin
      stall = 1'b1;
    end
    if (mem_pending && (read_sources_1 == mem_dest || read_sources_2 == mem_dest)) begin
      stall = 1'b1;
    end
  end

  assign write_enable      = we_reg;
  assign write_destination = dest_reg;
  assign write_data        = data_reg;
  assign wr_count          = count_reg;

endmodule
